// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared constants and types for the RISC-V front end.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam int          IMEM_AW   = 8;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Prefetch FIFO with flush; head is read straight from storage.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_do_pop;
    logic w_do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch PC, imem addressing and redirect handling over fetch_fifo.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc
);

    import riscv_pkg::*;

    logic [XLEN-1:0]       fetch_pc_q;
    logic [XLEN-1:0]       fetch_pc_d;
    fetch_entry_t          w_wr_entry;
    fetch_entry_t          w_rd_entry;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [$clog2(DEPTH):0] w_unused_count;

    assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

    // Redirect kills both sides of the FIFO for this cycle.
    assign w_pop  = if_valid && if_ready && !redirect_valid;
    assign w_push = !redirect_valid && (!w_full || (if_valid && if_ready));

    assign w_wr_entry.pc    = fetch_pc_q;
    assign w_wr_entry.instr = imem_rdata;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (w_push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (w_push),
        .wdata_i (w_wr_entry),
        .pop_i   (w_pop),
        .rdata_o (w_rd_entry),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_unused_count)
    );

    assign if_valid = !w_empty;
    assign if_instr = w_rd_entry.instr;
    assign if_pc    = w_rd_entry.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed and random checks of instr_fetch_unit against a queue model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;

    logic [31:0] mem [256];

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .IMEM_AW  (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a queue of {pc, instr} plus the next PC to fetch.
    logic [63:0] mq[$];
    logic [31:0] mpc = 32'h0;
    bit          mdl_live = 1'b0;
    bit          m_pop;
    bit          m_push;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mpc = 32'h0;
            mdl_live = 1'b1;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            m_pop  = (mq.size() > 0) && if_ready;
            m_push = (mq.size() < DEPTH) || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({mpc, mem[mpc[9:2]]});
                mpc = mpc + 32'd4;
            end
        end
    end

    logic [63:0] m_head;
    always @(negedge clk) begin
        if (mdl_live) begin
            chk("mdl_imem_addr", {24'h0, imem_addr}, {24'h0, mpc[9:2]});
            chk("mdl_if_valid", {31'h0, if_valid}, {31'h0, (mq.size() != 0)});
            if (mq.size() != 0) begin
                m_head = mq[0];
                chk("mdl_if_pc", if_pc, m_head[63:32]);
                chk("mdl_if_instr", if_instr, m_head[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00C0_0193;
        mem[2] = 32'hFF71_8393;

        // Reset state and stream
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        rst_n = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        chk("s0_valid", {31'h0, if_valid}, 32'h1);
        chk("s0_pc", if_pc, 32'h0);
        chk("s0_instr", if_instr, 32'h0050_0113);
        @(negedge clk);
        chk("s1_pc", if_pc, 32'h4);
        chk("s1_instr", if_instr, 32'h00C0_0193);
        @(negedge clk);
        chk("s2_pc", if_pc, 32'h8);
        chk("s2_instr", if_instr, 32'hFF71_8393);

        // Backpressure from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_instr", if_instr, 32'h0050_0113);
        end
        chk("bp_addr", {24'h0, imem_addr}, 32'h4);
        chk("bp_pc", if_pc, 32'h0);

        // Full FIFO with a single pop
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        chk("fp_pc", if_pc, 32'h4);
        chk("fp_addr", {24'h0, imem_addr}, 32'h5);
        @(negedge clk);
        chk("fp_hold_addr", {24'h0, imem_addr}, 32'h5);

        // Release: queued 8..16 then word 5 without gaps
        if_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("rel_pc", if_pc, 32'(4 + 4 * k));
        end

        // Redirect with three queued entries and a same-cycle handshake
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b0;
        repeat (3) @(negedge clk);
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rd_valid0", {31'h0, if_valid}, 32'h0);
        chk("rd_addr", {24'h0, imem_addr}, 32'd16);
        @(negedge clk);
        chk("rd_valid1", {31'h0, if_valid}, 32'h1);
        chk("rd_pc", if_pc, 32'h40);
        chk("rd_instr", if_instr, mem[16]);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_03F8;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("wr_addr0", {24'h0, imem_addr}, 32'd254);
        @(negedge clk);
        chk("wr_addr1", {24'h0, imem_addr}, 32'd255);
        chk("wr_pc0", if_pc, 32'h3F8);
        @(negedge clk);
        chk("wr_addr2", {24'h0, imem_addr}, 32'd0);
        chk("wr_pc1", if_pc, 32'h3FC);
        @(negedge clk);
        chk("wr_addr3", {24'h0, imem_addr}, 32'd1);
        chk("wr_pc2", if_pc, 32'h400);
        @(negedge clk);
        chk("wr_pc3", if_pc, 32'h404);

        // Reset beats redirect with a full FIFO
        if_ready = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        if_ready = 1'b1;
        @(negedge clk);
        chk("mr_valid", {31'h0, if_valid}, 32'h0);
        chk("mr_pc", if_pc, 32'h0);
        chk("mr_instr", if_instr, 32'h0);
        chk("mr_addr", {24'h0, imem_addr}, 32'h0);
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mr_restart_valid", {31'h0, if_valid}, 32'h1);
        chk("mr_restart_pc", if_pc, 32'h0);
        chk("mr_restart_instr", if_instr, 32'h0050_0113);

        // Randomized traffic, segments of differing decode pressure
        for (int seg = 0; seg < 60; seg++) begin
            int ready_pct;
            ready_pct = (seg % 3 == 0) ? 25 : ((seg % 3 == 1) ? 75 : 100);
            for (int c = 0; c < 50; c++) begin
                rst_n          = ($urandom_range(0, 199) != 0);
                redirect_valid = ($urandom_range(0, 19) == 0);
                redirect_pc    = $urandom;
                if_ready       = ($urandom_range(1, 100) <= ready_pct);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
